// File: rtl/ic_dest_part.sv
`default_nettype none
// ============================================================================
//  Module   : ic_dest_part
//  Purpose  : Destination-partition flit buffer. A small FIFO between the
//             interconnect and a partition, with delivery count and error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module ic_dest_part #(
  parameter int DWIDTH  = 36,
  parameter int NHWIDTH = 5,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic [DWIDTH-1:0]          in_data,
  input  logic [NHWIDTH-1:0]         in_nexthop,
  output logic                       in_ready,
  output logic                       fdp_valid,
  output logic [DWIDTH-1:0]          fdp_data,
  output logic [NHWIDTH-1:0]         fdp_nexthop,
  input  logic                       fdp_ack,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [15:0]                deliver_count,
  output logic                       error,
  output logic                       is_quiescent
);

  localparam int c_addr_w  = $clog2(DEPTH);
  localparam int c_occ_w   = c_addr_w + 1;
  localparam int c_entry_w = DWIDTH + NHWIDTH;
  localparam logic [c_occ_w-1:0] c_full = c_occ_w'(DEPTH);

  logic [c_entry_w-1:0] r_mem [DEPTH];
  logic [c_addr_w-1:0]  r_head;
  logic [c_addr_w-1:0]  r_tail;
  logic [c_occ_w-1:0]   r_occ;
  logic [15:0]          r_deliver_count;
  logic                 r_error;
  logic                 r_ready_en;

  logic w_push;
  logic w_pop;
  logic w_full;

  // in_ready depends only on registered state, so a full buffer stays closed
  // even when the head is consumed in the same cycle.
  assign w_full   = (r_occ == c_full);
  assign in_ready = r_ready_en & ~w_full;
  assign fdp_valid = (r_occ != '0) & enable;

  assign w_push = in_valid & in_ready;
  assign w_pop  = fdp_valid & fdp_ack;

  assign {fdp_data, fdp_nexthop} = r_mem[r_head];

  assign occupancy     = r_occ;
  assign deliver_count = r_deliver_count;
  assign error         = r_error;
  assign is_quiescent  = (r_occ == '0) & ~in_valid;

  // Payload storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= {in_data, in_nexthop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_occ           <= '0;
      r_deliver_count <= '0;
      r_error         <= 1'b0;
      r_ready_en      <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) begin
        r_tail <= r_tail + c_addr_w'(1);
      end
      if (w_pop) begin
        r_head          <= r_head + c_addr_w'(1);
        r_deliver_count <= r_deliver_count + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + c_occ_w'(1);
        2'b01:   r_occ <= r_occ - c_occ_w'(1);
        default: r_occ <= r_occ;
      endcase
      if (fdp_ack && !fdp_valid) begin
        r_error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ic_dest_part.md
IC_DEST_PART -- requirements
Module: ic_dest_part

Interface
REQ-001 Parameter DWIDTH, default 36, flit payload width driven on fdp_data.
REQ-002 Parameter NHWIDTH, default 5, nexthop width driven on fdp_nexthop.
REQ-003 Parameter DEPTH, default 4, buffer entries; power of two, >= 2.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 enable  input  1  1 = presentation of flits to partition permitted.
REQ-007 in_valid  input  1  interconnect offers a flit this cycle.
REQ-008 in_data  input  DWIDTH  offered flit payload.
REQ-009 in_nexthop  input  NHWIDTH  offered flit destination queue id.
REQ-010 in_ready  output  1  buffer can accept a flit this cycle.
REQ-011 fdp_valid  output  1  head flit presented to partition.
REQ-012 fdp_data  output  DWIDTH  head flit payload.
REQ-013 fdp_nexthop  output  NHWIDTH  head flit nexthop.
REQ-014 fdp_ack  input  1  OR of node acks; consumes head flit.
REQ-015 occupancy  output  log2(DEPTH)+1  buffered flit count.
REQ-016 deliver_count  output  16  flits delivered to partition, wrapping.
REQ-017 error  output  1  sticky protocol-violation flag.
REQ-018 is_quiescent  output  1  no buffered or offered flit.

Function
REQ-019 Push SHALL occur on a cycle with in_valid=1 and in_ready=1; {in_data,in_nexthop} written at tail, tail advances modulo DEPTH.
REQ-020 in_ready SHALL be 1 iff occupancy < DEPTH, derived from registered state only (no combinational path from fdp_ack).
REQ-021 When full, a same-cycle pop SHALL NOT enable a push; in_ready stays 0 that cycle.
REQ-022 fdp_valid SHALL equal (occupancy != 0) AND enable.
REQ-023 Pop SHALL occur on a cycle with fdp_valid=1 and fdp_ack=1; head advances modulo DEPTH, deliver_count increments by 1, wrapping 16'hFFFF -> 0.
REQ-024 fdp_data/fdp_nexthop SHALL reflect the head entry and remain stable while fdp_valid=1 and fdp_ack=0.
REQ-025 Latency: a flit pushed into an empty buffer SHALL appear with fdp_valid=1 on the next cycle (given enable=1); no bypass in the push cycle.
REQ-026 Simultaneous push and pop with 0 < occupancy < DEPTH SHALL leave occupancy unchanged; ordering strictly FIFO.
REQ-027 occupancy SHALL update next cycle as +1 push-only, -1 pop-only, unchanged otherwise.
REQ-028 enable=0 SHALL force fdp_valid=0 and block pops; pushes continue normally.
REQ-029 fdp_ack=1 while fdp_valid=0 SHALL set error=1 on the next edge; no pop, no count change.
REQ-030 error SHALL remain 1 until reset.
REQ-031 is_quiescent SHALL equal (occupancy == 0) AND NOT in_valid.
REQ-032 fdp_data/fdp_nexthop value when fdp_valid=0 is don't-care.

Reset
REQ-033 reset=0 SHALL asynchronously clear head, tail, occupancy, deliver_count and error to 0.
REQ-034 During reset: in_ready=0, fdp_valid=0, is_quiescent=NOT in_valid; in_ready=1 from the first edge after release.
REQ-035 Reset mid-operation SHALL discard all buffered flits; no flit delivered after release unless pushed after release.
REQ-036 Buffer storage SHALL need no reset.

Verification
REQ-037 Empty, enable=1, push data=0x00000000A, nexthop=3 at cycle T -> fdp_valid=1, fdp_data=0xA, fdp_nexthop=3 at T+1; ack at T+1 -> occupancy=0, deliver_count=1 at T+2.
REQ-038 Push 4 flits (0x1..0x4) with ack=0 -> occupancy=4, in_ready=0; in_valid=1 with ack=1 on the same cycle -> pop 0x1, no push, occupancy=3, in_ready=1 next cycle.
REQ-039 occupancy=2, push 0x5 and ack same cycle -> occupancy stays 2; delivery order 0x2,0x3,0x5 preserved.
REQ-040 enable=0 with occupancy=3, fdp_ack=1 for 5 cycles -> fdp_valid=0, no pops, error=1 after first ack cycle, stays 1.
REQ-041 deliver_count at 16'hFFFF, one pop -> deliver_count=0.
REQ-042 occupancy=3, reset pulsed low mid-cycle -> outputs cleared immediately; after release fdp_valid=0, in_ready=1, is_quiescent=1 with in_valid=0.
